reaction_timer_ctrl: RTL and testbench

//  Sequences one reaction-time trial around the 15-bit LFSR random source.
//  On start it takes the first in-range random value and scales it to a delay
//  in ms. It then lights the stimulus and measures the ms until the player's stop press.

---
 rtl/reaction_timer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time trial sequencer: waits for an in-range random value, holds the scaled delay, then times the stop press.
// Optional best-time tracking is enabled by defining RTC_BEST_TIME_EN.
module reaction_timer_ctrl #(
    parameter int TICKS_PER_MS  = 50000,
    parameter int DELAY_UNIT_MS = 100,
    parameter int RND_MIN       = 10,
    parameter int RND_MAX       = 50,
    parameter int TIMEOUT_MS    = 9999,
    parameter int RT_W          = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic [14:0]     rnd_value,
    input  logic            rnd_ready,
    output logic            stim_led,
    output logic            busy,
    output logic [RT_W-1:0] rt_ms,
    output logic            rt_valid,
    output logic            early,
    output logic            timeout,
    output logic [RT_W-1:0] best_ms,
    output logic [1:0]      dbg_state
);

    localparam int PS_W  = $clog2(TICKS_PER_MS + 1);
    localparam int DLY_W = 15 + $clog2(DELAY_UNIT_MS + 1);
    localparam int CNT_W = (DLY_W > RT_W) ? DLY_W : RT_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RND = 2'd1,
        S_DELAY    = 2'd2,
        S_MEASURE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]  ms_q, ms_d;
    logic [DLY_W-1:0]  delay_q, delay_d;
    logic              stim_q, stim_d;
    logic              busy_q, busy_d;
    logic [RT_W-1:0]   rt_ms_q, rt_ms_d;
    logic              rt_valid_q, rt_valid_d;
    logic              early_q, early_d;
    logic              timeout_q, timeout_d;
`ifdef RTC_BEST_TIME_EN
    logic [RT_W-1:0]   best_q, best_d;
`endif

    logic              ms_tick;
    logic              rnd_ok;
    logic [CNT_W-1:0]  ms_next;

    always_comb begin
        ms_tick = (presc_q == PS_W'(TICKS_PER_MS - 1));
        // The LFSR flag alone is not trusted; the range is rechecked here.
        rnd_ok  = rnd_ready && (rnd_value >= 15'(RND_MIN)) && (rnd_value <= 15'(RND_MAX));
        ms_next = ms_q + CNT_W'(1);

        state_d    = state_q;
        presc_d    = ms_tick ? '0 : presc_q + PS_W'(1);
        ms_d       = ms_q;
        delay_d    = delay_q;
        rt_ms_d    = rt_ms_q;
        rt_valid_d = 1'b0;
        early_d    = early_q;
        timeout_d  = timeout_q;
`ifdef RTC_BEST_TIME_EN
        best_d     = best_q;
`endif

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                ms_d    = '0;
                if (start) begin
                    state_d   = S_WAIT_RND;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_WAIT_RND: begin
                presc_d = '0;
                ms_d    = '0;
                if (stop) begin
                    early_d = 1'b1;
                    state_d = S_IDLE;
                end else if (rnd_ok) begin
                    delay_d = {{(DLY_W-15){1'b0}}, rnd_value} * DLY_W'(DELAY_UNIT_MS);
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                // An early press beats a delay expiring on the same cycle.
                if (stop) begin
                    early_d = 1'b1;
                    state_d = S_IDLE;
                end else if (ms_tick) begin
                    if (ms_next == CNT_W'(delay_q)) begin
                        state_d = S_MEASURE;
                        presc_d = '0;
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_next;
                    end
                end
            end
            S_MEASURE: begin
                // Reaching the limit beats a stop press on the same cycle.
                if (ms_tick && (ms_next == CNT_W'(TIMEOUT_MS))) begin
                    rt_ms_d    = RT_W'(TIMEOUT_MS);
                    timeout_d  = 1'b1;
                    rt_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (stop) begin
                    rt_ms_d    = RT_W'(ms_q);
                    rt_valid_d = 1'b1;
                    state_d    = S_IDLE;
`ifdef RTC_BEST_TIME_EN
                    if (RT_W'(ms_q) < best_q) best_d = RT_W'(ms_q);
`endif
                end else if (ms_tick) begin
                    ms_d = ms_next;
                end
            end
            default: state_d = S_IDLE;
        endcase

        stim_d = (state_d == S_MEASURE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            ms_q       <= '0;
            delay_q    <= '0;
            stim_q     <= 1'b0;
            busy_q     <= 1'b0;
            rt_ms_q    <= '0;
            rt_valid_q <= 1'b0;
            early_q    <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef RTC_BEST_TIME_EN
            best_q     <= '1;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ms_q       <= ms_d;
            delay_q    <= delay_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            rt_ms_q    <= rt_ms_d;
            rt_valid_q <= rt_valid_d;
            early_q    <= early_d;
            timeout_q  <= timeout_d;
`ifdef RTC_BEST_TIME_EN
            best_q     <= best_d;
`endif
        end
    end

    assign stim_led  = stim_q;
    assign busy      = busy_q;
    assign rt_ms     = rt_ms_q;
    assign rt_valid  = rt_valid_q;
    assign early     = early_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;
`ifdef RTC_BEST_TIME_EN
    assign best_ms   = best_q;
`else
    assign best_ms   = '1;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a 4-cycle ms tick, 2 ms delay unit and 20 ms limit.
module tb_reaction_timer_ctrl;

    localparam int RT_W = 14;
    localparam int ALL1 = 16383;
`ifdef RTC_BEST_TIME_EN
    localparam int BEST_EXP = 5;
`else
    localparam int BEST_EXP = ALL1;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            stop;
    logic [14:0]     rnd_value;
    logic            rnd_ready;
    logic            stim_led;
    logic            busy;
    logic [RT_W-1:0] rt_ms;
    logic            rt_valid;
    logic            early;
    logic            timeout;
    logic [RT_W-1:0] best_ms;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(
        .TICKS_PER_MS (4),
        .DELAY_UNIT_MS(2),
        .RND_MIN      (10),
        .RND_MAX      (50),
        .TIMEOUT_MS   (20),
        .RT_W         (RT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .rnd_value(rnd_value),
        .rnd_ready(rnd_ready),
        .stim_led (stim_led),
        .busy     (busy),
        .rt_ms    (rt_ms),
        .rt_valid (rt_valid),
        .early    (early),
        .timeout  (timeout),
        .best_ms  (best_ms),
        .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_trial();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic capture(input int v);
        rnd_value = 15'(v);
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
    endtask

    task automatic press();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Full trial: delay_clk cycles of DELAY, then stop k cycles into MEASURE.
    task automatic trial(input string tag, input int v, input int delay_clk, input int k, input int exp_rt);
        start_trial();
        capture(v);
        repeat (delay_clk) tick();
        check({tag, "_stim"}, 32'(stim_led), 1);
        repeat (k) tick();
        press();
        check({tag, "_valid"}, 32'(rt_valid), 1);
        check({tag, "_rt"}, 32'(rt_ms), exp_rt);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        rnd_value = '0;
        rnd_ready = 1'b0;
        repeat (2) tick();
        check("rst_stim", 32'(stim_led), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rt", 32'(rt_ms), 0);
        check("rst_valid", 32'(rt_valid), 0);
        check("rst_early", 32'(early), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_best", 32'(best_ms), ALL1);
        reset = 1'b0;
        tick();

        // Normal trial: capture 10 -> 20 ms -> stim at C+81, stop 28 clk later -> 7 ms.
        start_trial();
        check("t1_busy", 32'(busy), 1);
        check("t1_state_wait", 32'(dbg_state), 1);
        capture(10);
        check("t1_state_delay", 32'(dbg_state), 2);
        repeat (79) tick();
        check("t1_stim_before", 32'(stim_led), 0);
        tick();
        check("t1_stim_rise", 32'(stim_led), 1);
        repeat (28) tick();
        press();
        check("t1_valid", 32'(rt_valid), 1);
        check("t1_rt", 32'(rt_ms), 7);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_stim_end", 32'(stim_led), 0);
        tick();
        check("t1_valid_pulse", 32'(rt_valid), 0);
        check("t1_rt_hold", 32'(rt_ms), 7);

        trial("t2", 10, 80, 20, 5);
        trial("t3", 12, 96, 37, 9);

        // Range gate: 9, 60 and an unflagged 30 rejected, 25 captured -> 50 ms = 200 clk.
        start_trial();
        rnd_value = 15'd9;  rnd_ready = 1'b1; tick();
        check("gate_low", 32'(dbg_state), 1);
        rnd_value = 15'd60; tick();
        check("gate_high", 32'(dbg_state), 1);
        rnd_value = 15'd30; rnd_ready = 1'b0; tick();
        check("gate_noready", 32'(dbg_state), 1);
        capture(25);
        check("gate_take", 32'(dbg_state), 2);
        repeat (199) tick();
        check("gate_stim_before", 32'(stim_led), 0);
        tick();
        check("gate_stim_rise", 32'(stim_led), 1);

        // Timeout: no stop -> 80 clk later rt_ms = 20.
        repeat (79) tick();
        check("to_valid_before", 32'(rt_valid), 0);
        check("to_busy_before", 32'(busy), 1);
        tick();
        check("to_valid", 32'(rt_valid), 1);
        check("to_rt", 32'(rt_ms), 20);
        check("to_flag", 32'(timeout), 1);
        check("to_busy", 32'(busy), 0);
        check("best_after_to", 32'(best_ms), BEST_EXP);

        // Stop on the same cycle as the limit: timeout wins.
        start_trial();
        check("to_cleared", 32'(timeout), 0);
        capture(10);
        repeat (80) tick();
        repeat (79) tick();
        press();
        check("tie_timeout", 32'(timeout), 1);
        check("tie_rt", 32'(rt_ms), 20);
        check("tie_valid", 32'(rt_valid), 1);

        // Early press in DELAY.
        start_trial();
        capture(10);
        repeat (10) tick();
        press();
        check("early_flag", 32'(early), 1);
        check("early_valid", 32'(rt_valid), 0);
        check("early_rt", 32'(rt_ms), 20);
        check("early_stim", 32'(stim_led), 0);
        check("early_busy", 32'(busy), 0);
        start_trial();
        check("early_cleared", 32'(early), 0);
        // Early press in WAIT_RND.
        press();
        check("early_wait", 32'(early), 1);
        check("early_wait_busy", 32'(busy), 0);

        // Stop on the last DELAY cycle: early wins over stimulus.
        start_trial();
        capture(10);
        repeat (79) tick();
        press();
        check("edge_early", 32'(early), 1);
        check("edge_stim", 32'(stim_led), 0);
        check("edge_state", 32'(dbg_state), 0);

        // start in MEASURE is ignored; stop 8 clk into MEASURE -> 2 ms.
        start_trial();
        capture(10);
        repeat (80) tick();
        start = 1'b1; tick(); start = 1'b0;
        check("ign_start_state", 32'(dbg_state), 3);
        check("ign_start_stim", 32'(stim_led), 1);
        repeat (7) tick();
        press();
        check("ign_start_rt", 32'(rt_ms), 2);
        check("ign_start_early", 32'(early), 0);

        // stop in IDLE is ignored.
        press();
        check("idle_stop_valid", 32'(rt_valid), 0);
        check("idle_stop_early", 32'(early), 0);
        check("idle_stop_busy", 32'(busy), 0);

        // Asynchronous reset mid-DELAY.
        start_trial();
        capture(10);
        repeat (5) tick();
        check("mid_state", 32'(dbg_state), 2);
        reset = 1'b1;
        #1;
        check("mr_state", 32'(dbg_state), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_rt", 32'(rt_ms), 0);
        check("mr_timeout", 32'(timeout), 0);
        check("mr_best", 32'(best_ms), ALL1);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
